// File: rtl/des_keysched_if.sv
// Handshake bundle for the DES key-schedule controller: start/key request side
// and the round-key stream with its valid/ready handshake.
interface des_keysched_if;
   logic        start;
   logic        decrypt;
   logic [63:0] KEY;
   logic        idle;
   logic        rk_valid;
   logic        rk_ready;
   logic [47:0] round_key;
   logic [3:0]  round_idx;
   logic        done;

   modport master (
      output start, decrypt, KEY, rk_ready,
      input  idle, rk_valid, round_key, round_idx, done
   );

   modport slave (
      input  start, decrypt, KEY, rk_ready,
      output idle, rk_valid, round_key, round_idx, done
   );
endinterface

// File: rtl/des_keysched_ctrl.sv
// DES 16-round key schedule streamed over a valid/ready handshake.
// Optional macro DES_KEYSCHED_DECRYPT_EN adds reverse (K16..K1) emission order.

// PC-1: 64-bit key (KEY[i] = FIPS bit i+1) to 56-bit C/D, parity bits dropped.
module des_pc1 (
   input  logic [63:0] key,
   output logic [55:0] pc1
);
   // Zero-based source bit for each PC-1 output position.
   localparam logic [5:0] PC1_TAB [56] = '{
      6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,  6'd0,
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
      6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
      6'd59, 6'd51, 6'd43, 6'd35, 6'd62, 6'd54, 6'd46, 6'd38,
      6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
      6'd29, 6'd21, 6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd28, 6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
   };

   logic unused_parity_s;

   for (genvar j = 0; j < 56; j++) begin : g_bit
      assign pc1[j] = key[PC1_TAB[j]];
   end

   assign unused_parity_s = ^{key[63], key[55], key[47], key[39],
                              key[31], key[23], key[15], key[7]};
endmodule

module des_keysched_ctrl (
   input logic           clk,
   input logic           rst_n,
   des_keysched_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [5:0] PC2_TAB [48] = '{
      6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,  6'd2,  6'd27,
      6'd14, 6'd5,  6'd20, 6'd9,  6'd22, 6'd18, 6'd11, 6'd3,
      6'd25, 6'd7,  6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
      6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54, 6'd29, 6'd39,
      6'd50, 6'd44, 6'd32, 6'd47, 6'd43, 6'd48, 6'd38, 6'd55,
      6'd33, 6'd52, 6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
   };

   // PC-2 over cd = {D, C}, so cd[k-1] is FIPS C/D bit k.
   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] k;
      for (int j = 0; j < 48; j++) begin
         k[j] = cd[PC2_TAB[j]];
      end
      return k;
   endfunction

   // FIPS bit 1 sits at index 0, so a FIPS left rotate moves bits toward index 0.
   function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] amt,
                                         input logic right);
      logic [27:0] r;
      case (amt)
         2'd1:    r = right ? {v[26:0], v[27]}    : {v[0], v[27:1]};
         2'd2:    r = right ? {v[25:0], v[27:26]} : {v[1:0], v[27:2]};
         default: r = v;
      endcase
      return r;
   endfunction

   state_t      state_r, state_nxt_s;
   logic [27:0] c_r, d_r;
   logic [47:0] round_key_r;
   logic [3:0]  round_idx_r;
   logic [55:0] pc1_s;
   logic        load_s, hs_s, last_s;
   logic [3:0]  step_s;
   logic [27:0] base_c_s, base_d_s, nxt_c_s, nxt_d_s;
   logic [1:0]  amt_s;
   logic        right_s;
   logic [47:0] nxt_key_s;
   logic        idle_s, rk_valid_s, done_s;

   des_pc1 u_pc1 (
      .key (bus.KEY),
      .pc1 (pc1_s)
   );

`ifdef DES_KEYSCHED_DECRYPT_EN
   logic dec_r;

   // Direction latched at acceptance; later decrypt changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_r <= 1'b0;
      end else if (load_s) begin
         dec_r <= bus.decrypt;
      end
   end
`else
   logic unused_decrypt_s;
   assign unused_decrypt_s = bus.decrypt;
`endif

   // Handshake qualifiers.
   always_comb begin
      load_s = (state_r == ST_IDLE) && bus.start;
      hs_s   = (state_r == ST_ROUND) && bus.rk_ready;
      last_s = (round_idx_r == 4'd15);
      step_s = round_idx_r + 4'd1;
   end

   // Next C/D and round key: load path rotates fresh PC-1, advance path rotates C/D.
   always_comb begin
      base_c_s = c_r;
      base_d_s = d_r;
      amt_s    = 2'd2;
      right_s  = 1'b0;
      if (load_s) begin
         base_c_s = pc1_s[27:0];
         base_d_s = pc1_s[55:28];
`ifdef DES_KEYSCHED_DECRYPT_EN
         amt_s    = bus.decrypt ? 2'd0 : 2'd1;
`else
         amt_s    = 2'd1;
`endif
      end else begin
         // Single-step positions coincide for both orders once past the first key.
         if ((step_s == 4'd1) || (step_s == 4'd8) || (step_s == 4'd15)) begin
            amt_s = 2'd1;
         end else begin
            amt_s = 2'd2;
         end
`ifdef DES_KEYSCHED_DECRYPT_EN
         right_s = dec_r;
`endif
      end
      nxt_c_s   = rot28(base_c_s, amt_s, right_s);
      nxt_d_s   = rot28(base_d_s, amt_s, right_s);
      nxt_key_s = pc2({nxt_d_s, nxt_c_s});
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_ROUND;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ROUND: begin
            if (hs_s && last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_ROUND;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from the state register.
   always_comb begin
      idle_s     = 1'b0;
      rk_valid_s = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         ST_IDLE:  idle_s     = 1'b1;
         ST_ROUND: rk_valid_s = 1'b1;
         ST_DONE:  done_s     = 1'b1;
         default:  idle_s     = 1'b0;
      endcase
   end

   // Key datapath: load on acceptance, advance on every non-final handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_r         <= 28'd0;
         d_r         <= 28'd0;
         round_key_r <= 48'd0;
         round_idx_r <= 4'd0;
      end else if (load_s || (hs_s && !last_s)) begin
         c_r         <= nxt_c_s;
         d_r         <= nxt_d_s;
         round_key_r <= nxt_key_s;
         round_idx_r <= load_s ? 4'd0 : step_s;
      end
   end

   assign bus.idle      = idle_s;
   assign bus.rk_valid  = rk_valid_s;
   assign bus.done      = done_s;
   assign bus.round_key = round_key_r;
   assign bus.round_idx = round_idx_r;
endmodule

// File: tb/tb_des_keysched_ctrl.sv
// Bench for des_keysched_ctrl: vector table of schedules checked through a
// scoreboard fed by an independent FIPS-ordered key-schedule model.
module tb_des_keysched_ctrl;
   localparam int HALF   = 5;
   localparam int BUDGET = 2000;
   localparam logic [47:0] K1    = 48'h1B02EFFC7072;
   localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;
   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;
`ifdef DES_KEYSCHED_DECRYPT_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif
   localparam logic [47:0] DEC_FIRST = DEC_EN ? K16 : K1;
   localparam logic [47:0] DEC_LAST  = DEC_EN ? K1 : K16;

   // FIPS tables, 1-based, bit 1 = MSB of the hex value.
   localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
      10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23,
      15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
   localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19,
      12, 4, 26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33,
      48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   typedef struct {
      logic [63:0] key;
      logic        dec;
      int          pct;
      int          mode;
      logic        chk;
      logic [47:0] first;
      logic [47:0] last;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   logic [47:0] exp_q [$];
   logic [47:0] model_k [16];
   vec_t vecs [8];

   always #HALF clk = ~clk;

   des_keysched_if bus ();

   des_keysched_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [63:0] rev64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[63 - i] = v[i];
      return r;
   endfunction

   function automatic logic [47:0] rev48(input logic [47:0] v);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[47 - i] = v[i];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic build_model(input logic [63:0] k, input logic dec);
      logic [55:0] cd, cdr;
      logic [27:0] c, d;
      logic [47:0] kk;
      logic [47:0] enc [16];
      int sh;
      for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 1; r <= 16; r++) begin
         sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
         for (int s = 0; s < sh; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cdr = {c, d};
         for (int j = 0; j < 48; j++) kk[47 - j] = cdr[56 - PC2_T[j]];
         enc[r - 1] = kk;
      end
      for (int e = 0; e < 16; e++) model_k[e] = (dec && DEC_EN) ? enc[15 - e] : enc[e];
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_sched(input vec_t v, output logic [47:0] first_k,
                            output logic [47:0] last_k);
      int hs, cyc;
      logic inj, aborted;
      build_model(v.key, v.dec);
      for (int e = 0; e < 16; e++) exp_q.push_back(model_k[e]);
      first_k = 48'd0;
      last_k  = 48'd0;
      check("idle_before_start", 64'(bus.idle), 64'd1);
      bus.KEY     = rev64(v.key);
      bus.decrypt = v.dec;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.KEY     = {$urandom, $urandom};
      bus.decrypt = ~v.dec;
      hs = 0;
      cyc = 0;
      inj = 1'b0;
      aborted = 1'b0;
      while (hs < 16 && cyc < BUDGET && !aborted) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (v.mode == 2 && hs == 8) begin
            bus.rk_ready = 1'b0;
            rst_n = 1'b0;
            #1;
            check("rst_mid_valid", 64'(bus.rk_valid), 64'd0);
            check("rst_mid_done", 64'(bus.done), 64'd0);
            check("rst_mid_idle", 64'(bus.idle), 64'd1);
            check("rst_mid_key", 64'(bus.round_key), 64'd0);
            check("rst_mid_idx", 64'(bus.round_idx), 64'd0);
            exp_q.delete();
            aborted = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            check("valid_in_round", 64'(bus.rk_valid), 64'd1);
            check("round_key", 64'(rev48(bus.round_key)), 64'(exp_q[0]));
            check("round_idx", 64'(bus.round_idx), 64'(hs));
            if (bus.done !== 1'b0) check("early_done", 64'(bus.done), 64'd0);
            if (v.mode == 1 && hs == 5 && !inj) begin
               bus.start = 1'b1;
               bus.KEY   = ~rev64(v.key);
               inj = 1'b1;
            end
            bus.rk_ready = ($urandom_range(99) < v.pct) ? 1'b1 : 1'b0;
            if (bus.rk_ready) begin
               if (hs == 0) first_k = rev48(bus.round_key);
               if (hs == 15) last_k = rev48(bus.round_key);
               void'(exp_q.pop_front());
               hs++;
            end
         end
      end
      if (!aborted) begin
         if (hs < 16) check("handshake_timeout", 64'(hs), 64'd16);
         @(negedge clk);
         bus.start    = 1'b0;
         bus.rk_ready = 1'b0;
         check("done_pulse", 64'(bus.done), 64'd1);
         check("valid_dropped", 64'(bus.rk_valid), 64'd0);
         check("key_held_done", 64'(rev48(bus.round_key)), 64'(model_k[15]));
         if (v.pct == 100 && v.mode == 0) check("done_latency", 64'(cyc + 1), 64'd17);
         @(negedge clk);
         check("done_one_cycle", 64'(bus.done), 64'd0);
         check("idle_after", 64'(bus.idle), 64'd1);
         check("key_held_idle", 64'(rev48(bus.round_key)), 64'(model_k[15]));
      end
   endtask

   initial begin
      logic [47:0] fk, lk;
      vecs[0] = '{KEY_A, 1'b0, 100, 0, 1'b1, K1, K16};
      vecs[1] = '{KEY_A, 1'b1, 100, 0, 1'b1, DEC_FIRST, DEC_LAST};
      vecs[2] = '{KEY_A, 1'b0, 30, 0, 1'b1, K1, K16};
      vecs[3] = '{KEY_P, 1'b0, 70, 0, 1'b1, K1, K16};
      vecs[4] = '{64'h0E329232EA6D0D73, 1'b1, 50, 0, 1'b0, 48'd0, 48'd0};
      vecs[5] = '{KEY_A, 1'b0, 60, 1, 1'b1, K1, K16};
      vecs[6] = '{64'h0123456789ABCDEF, 1'b0, 80, 2, 1'b0, 48'd0, 48'd0};
      vecs[7] = '{KEY_A, 1'b0, 100, 0, 1'b1, K1, K16};

      bus.start    = 1'b0;
      bus.decrypt  = 1'b0;
      bus.KEY      = 64'd0;
      bus.rk_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_idle", 64'(bus.idle), 64'd1);
      check("rst_valid", 64'(bus.rk_valid), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_key", 64'(bus.round_key), 64'd0);
      check("rst_idx", 64'(bus.round_idx), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_sched(vecs[i], fk, lk);
         if (vecs[i].chk) begin
            check($sformatf("first_key_v%0d", i), 64'(fk), 64'(vecs[i].first));
            check($sformatf("last_key_v%0d", i), 64'(lk), 64'(vecs[i].last));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
